// File: rtl/mbf_subband_packer_if.sv
// Sample inputs and the serialised output port of the subband packer.
// The producer/consumer side uses master; the packer itself uses slave.
interface mbf_subband_packer_if #(
  parameter int IDX_W = 9
) ();
  logic             y_valid;
  logic [7:0]       y;
  logic             z_valid;
  logic [7:0]       z;
  logic             out_ready;
  logic             out_valid;
  logic             out_band;
  logic [7:0]       out_data;
  logic [IDX_W-1:0] out_idx;
  logic [1:0]       ovf;

  modport master (
    output y_valid, y, z_valid, z, out_ready,
    input  out_valid, out_band, out_data, out_idx, ovf
  );

  modport slave (
    input  y_valid, y, z_valid, z, out_ready,
    output out_valid, out_band, out_data, out_idx, ovf
  );
endinterface

// File: rtl/mbf_subband_packer.sv
// Decimate-by-2 of the low (y) and high (z) bands into per-band FIFOs,
// then round-robin serialisation onto one tagged ready/valid output slot.
module mbf_subband_packer #(
  parameter int DEPTH = 16,
  parameter int IDX_W = 9
) (
  input logic                 clk,
  input logic                 reset,
  mbf_subband_packer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = IDX_W + 8;

  // Asynchronous assertion, deassertion released through two flops.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_n;

  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync_q <= '0;
    else        rst_sync_q <= rst_sync_d;
  end

  assign rst_n = rst_sync_q[1];

  logic [1:0]    in_valid;
  logic [7:0]    in_data [2];
  logic [1:0]    nonempty;
  logic [1:0]    pop;
  logic [1:0]    ovf_bits;
  logic [WW-1:0] rd_word [2];

  assign in_valid   = {bus.z_valid, bus.y_valid};
  assign in_data[0] = bus.y;
  assign in_data[1] = bus.z;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_band
      logic             phase_q, phase_d;
      logic [IDX_W-1:0] idx_q, idx_d;
      logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
      logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
      logic [CW-1:0]    cnt_q, cnt_d;
      logic             ovf_q, ovf_d;
      logic             keep;
      logic             wr;
      logic [WW-1:0]    mem_q [DEPTH];

      always_comb begin
        keep     = in_valid[gi] && !phase_q;
        // A full FIFO still accepts when it is popped on the same edge.
        wr       = keep && ((cnt_q != CW'(DEPTH)) || pop[gi]);
        phase_d  = phase_q ^ in_valid[gi];
        idx_d    = idx_q + IDX_W'(keep);
        wr_ptr_d = wr_ptr_q + AW'(wr);
        rd_ptr_d = rd_ptr_q + AW'(pop[gi]);
        cnt_d    = cnt_q + CW'(wr) - CW'(pop[gi]);
        ovf_d    = ovf_q || (keep && !wr);
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          phase_q  <= 1'b0;
          idx_q    <= '0;
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          cnt_q    <= '0;
          ovf_q    <= 1'b0;
        end else begin
          phase_q  <= phase_d;
          idx_q    <= idx_d;
          wr_ptr_q <= wr_ptr_d;
          rd_ptr_q <= rd_ptr_d;
          cnt_q    <= cnt_d;
          ovf_q    <= ovf_d;
        end
      end

      always_ff @(posedge clk) begin
        if (wr) mem_q[wr_ptr_q] <= {idx_q, in_data[gi]};
      end

      assign nonempty[gi] = (cnt_q != '0);
      assign rd_word[gi]  = mem_q[rd_ptr_q];
      assign ovf_bits[gi] = ovf_q;
    end
  endgenerate

  logic             out_valid_q, out_valid_d;
  logic             out_band_q, out_band_d;
  logic [7:0]       out_data_q, out_data_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  logic             ptr_q, ptr_d;
  logic             slot_free;
  logic             grant_band;

  always_comb begin
    slot_free   = !out_valid_q || bus.out_ready;
    grant_band  = (&nonempty) ? ptr_q : nonempty[1];
    pop         = '0;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_band_d  = out_band_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    if (slot_free) begin
      out_valid_d = |nonempty;
      if (|nonempty) begin
        pop[grant_band]         = 1'b1;
        ptr_d                   = !grant_band;
        out_band_d              = grant_band;
        {out_idx_d, out_data_d} = rd_word[grant_band];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_band_q  <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      ptr_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_band_q  <= out_band_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_band  = out_band_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.ovf       = ovf_bits;
endmodule

// File: tb/tb_mbf_subband_packer.sv
// Directed and randomised checks of mbf_subband_packer against a queue-based
// model of the decimate / buffer / round-robin behaviour.
module tb_mbf_subband_packer;
  localparam int DEPTH = 16;
  localparam int IDX_W = 9;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mbf_subband_packer_if #(.IDX_W(IDX_W)) bus ();

  mbf_subband_packer #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Model state: queues hold idx*256 + data per band.
  bit       m_phase [2];
  int       m_idx   [2];
  bit [1:0] m_ovf;
  bit       m_v, m_band, m_ptr;
  int       m_data, m_oidx;
  int       q0[$];
  int       q1[$];

  // Capture of accepted words and low-band index tracking.
  bit capture;
  int obs_band[$];
  int obs_data[$];
  int obs_idx[$];
  int last_low;
  bit saw_max;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int b = 0; b < 2; b++) begin
      m_phase[b] = 1'b0;
      m_idx[b]   = 0;
    end
    m_ovf  = 2'b00;
    m_v    = 1'b0;
    m_band = 1'b0;
    m_ptr  = 1'b0;
    m_data = 0;
    m_oidx = 0;
    q0.delete();
    q1.delete();
  endfunction

  function automatic void model_step(bit yv, bit [7:0] yd, bit zv, bit [7:0] zd, bit rdy);
    bit free;
    int gb;
    int w;
    int sz;
    bit vin [2];
    int din [2];
    free = !m_v || rdy;
    gb   = -1;
    if (free) begin
      if (q0.size() > 0 && q1.size() > 0) gb = int'(m_ptr);
      else if (q0.size() > 0)             gb = 0;
      else if (q1.size() > 0)             gb = 1;
      if (gb < 0) m_v = 1'b0;
      else begin
        w      = (gb == 0) ? q0.pop_front() : q1.pop_front();
        m_v    = 1'b1;
        m_band = (gb == 1);
        m_data = w % 256;
        m_oidx = w / 256;
        m_ptr  = (gb == 0);
      end
    end
    vin[0] = yv; vin[1] = zv;
    din[0] = int'(yd); din[1] = int'(zd);
    for (int b = 0; b < 2; b++) begin
      if (vin[b]) begin
        if (!m_phase[b]) begin
          sz = (b == 0) ? q0.size() : q1.size();
          if (sz < DEPTH) begin
            if (b == 0) q0.push_back(m_idx[b] * 256 + din[b]);
            else        q1.push_back(m_idx[b] * 256 + din[b]);
          end else begin
            m_ovf[b] = 1'b1;
          end
          m_idx[b] = (m_idx[b] + 1) % (1 << IDX_W);
        end
        m_phase[b] = !m_phase[b];
      end
    end
  endfunction

  task automatic compare_outputs();
    check("out_valid", bus.out_valid, m_v);
    if (m_v) begin
      check("out_band", bus.out_band, m_band);
      check("out_data", bus.out_data, m_data);
      check("out_idx",  bus.out_idx,  m_oidx);
    end
    check("ovf", bus.ovf, m_ovf);
    if (bus.out_valid === 1'b1) begin
      if (capture) begin
        obs_band.push_back(int'(bus.out_band));
        obs_data.push_back(int'(bus.out_data));
        obs_idx.push_back(int'(bus.out_idx));
      end
      if (bus.out_band === 1'b0) begin
        last_low = int'(bus.out_idx);
        if (bus.out_idx === 9'd511) saw_max = 1'b1;
      end
    end
  endtask

  // One clock: drive at negedge, model at posedge, compare at next negedge.
  task automatic cyc(input bit yv, input logic [7:0] yd, input bit zv, input logic [7:0] zd, input bit rdy);
    bus.y_valid   = yv;
    bus.y         = yd;
    bus.z_valid   = zv;
    bus.z         = zd;
    bus.out_ready = rdy;
    @(posedge clk);
    model_step(yv, yd, zv, zd, rdy);
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic do_reset();
    bus.y_valid   = 1'b0;
    bus.y         = '0;
    bus.z_valid   = 1'b0;
    bus.z         = '0;
    bus.out_ready = 1'b1;
    reset = 1'b0;
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_band",  bus.out_band,  0);
    check("rst_out_data",  bus.out_data,  0);
    check("rst_out_idx",   bus.out_idx,   0);
    check("rst_ovf",       bus.ovf,       0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (4) cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    int exp_band [8];
    int exp_data [8];
    int exp_idx  [8];
    logic [7:0] zval;

    capture  = 1'b0;
    last_low = -1;
    saw_max  = 1'b0;
    #2;
    do_reset();

    // Both bands streaming, consumer always ready.
    exp_band = '{0, 1, 0, 1, 0, 1, 0, 1};
    exp_data = '{8'h01, 8'hFF, 8'h03, 8'hFD, 8'h05, 8'hFB, 8'h07, 8'hF9};
    exp_idx  = '{0, 0, 1, 1, 2, 2, 3, 3};
    capture  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      zval = 8'(-(i + 1));
      cyc(1'b1, 8'(i + 1), 1'b1, zval, 1'b1);
    end
    repeat (6) cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    capture = 1'b0;
    check("t1_count", obs_band.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < obs_band.size()) begin
        check("t1_band", obs_band[i], exp_band[i]);
        check("t1_data", obs_data[i], exp_data[i]);
        check("t1_idx",  obs_idx[i],  exp_idx[i]);
      end
    end
    check("t1_ovf", bus.ovf, 0);

    // Alternate-cycle low-band pulses: only 10 and 12 survive.
    do_reset();
    obs_band.delete(); obs_data.delete(); obs_idx.delete();
    capture = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 8'(10 + i), 1'b0, 8'h00, 1'b1);
      cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    end
    repeat (3) cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    capture = 1'b0;
    check("t2_count", obs_band.size(), 2);
    if (obs_band.size() == 2) begin
      check("t2_band0", obs_band[0], 0);
      check("t2_data0", obs_data[0], 10);
      check("t2_idx0",  obs_idx[0],  0);
      check("t2_band1", obs_band[1], 0);
      check("t2_data1", obs_data[1], 12);
      check("t2_idx1",  obs_idx[1],  1);
    end

    // Stalled consumer with both bands streaming until both FIFOs overflow.
    do_reset();
    for (int i = 0; i < 40; i++) cyc(1'b1, 8'($urandom), 1'b1, 8'($urandom), 1'b0);
    check("stall_ovf", bus.ovf, 2'b11);
    check("stall_first_idx", bus.out_idx, 0);
    for (int i = 0; i < 10; i++) cyc(1'b1, 8'($urandom), 1'b1, 8'($urandom), 1'b1);

    // Short asynchronous reset pulse while a word is on the output.
    check("mid_valid_before", bus.out_valid, 1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_out_valid", bus.out_valid, 0);
    check("mid_ovf",       bus.ovf,       0);
    check("mid_out_idx",   bus.out_idx,   0);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    repeat (4) cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    cyc(1'b1, 8'h55, 1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    check("mid_first_valid", bus.out_valid, 1);
    check("mid_first_idx",   bus.out_idx,   0);
    check("mid_first_data",  bus.out_data,  8'h55);
    repeat (3) cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

    // Full low FIFO popped on the same edge a kept sample arrives.
    do_reset();
    for (int i = 0; i < 33; i++) cyc(1'b1, 8'($urandom), 1'b0, 8'h00, 1'b0);
    cyc(1'b1, 8'($urandom), 1'b0, 8'h00, 1'b0);
    check("full_pre_ovf", bus.ovf, 0);
    cyc(1'b1, 8'hA5, 1'b0, 8'h00, 1'b1);
    check("full_pop_ovf", bus.ovf, 0);
    repeat (40) cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

    // Long low-band stream exercising index wrap.
    do_reset();
    last_low = -1;
    saw_max  = 1'b0;
    for (int i = 0; i < 1100; i++) cyc(1'b1, 8'($urandom), 1'b0, 8'h00, 1'b1);
    repeat (6) cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    check("wrap_saw_511", saw_max, 1);
    check("wrap_last_idx", last_low, 37);

    // Randomised traffic with random back-pressure.
    do_reset();
    for (int i = 0; i < 1500; i++)
      cyc(1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom), ($urandom_range(3) != 0));
    repeat (60) cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    check("rand_drained", bus.out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/mbf_subband_packer.md
# mbf_subband_packer

Downstream stage of the multi-bank filter. Consumes the low-band (`y`) and high-band (`z`) 8-bit sample streams, decimates each band by 2, and buffers each band in its own FIFO. It then serialises both bands onto one ready/valid output port, tagging each word with its band and a decimated sample index. Dropped samples are flagged by sticky overflow bits.

## Interface
Parameters:
- `DEPTH`, 16: entries per band FIFO; power of two, ≥ 2.
- `IDX_W`, 9: width of the per-band decimated sample index.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  reset; one clock; reset is asynchronous and active-low.
- `y_valid`  in  1  low-band sample valid.
- `y`  in  8  low-band sample, two's complement.
- `z_valid`  in  1  high-band sample valid.
- `z`  in  8  high-band sample, two's complement.
- `out_ready`  in  1  consumer accepts the output word this cycle.
- `out_valid`  out  1  output word present.
- `out_band`  out  1  0 = low band (`y`), 1 = high band (`z`).
- `out_data`  out  8  sample value, passed unmodified.
- `out_idx`  out  IDX_W  decimated index of the sample within its band.
- `ovf`  out  2  sticky overflow flags: bit0 = low band, bit1 = high band.

## Operation
- Each band runs independently with its own phase bit, index counter, FIFO and overflow bit.
- Decimation:
  - The phase bit toggles on every cycle the band's valid input is high.
  - A sample is kept when phase = 0 before the toggle, so the first valid sample after reset is kept.
  - Samples taken at phase = 1 are discarded.
- Index:
  - The index counter increments on every kept sample, whether or not the sample is stored.
  - It wraps from 2^IDX_W−1 to 0.
  - The stored index is the value before the increment.
  - A gap in `out_idx` therefore marks a dropped sample.
- FIFO write:
  - A kept sample is written when count < DEPTH, or when count = DEPTH and the same FIFO is popped this cycle.
  - Otherwise the sample is dropped and the band's `ovf` bit is set. The bit clears only on reset.
- Output register: a single output slot (`out_valid`, `out_band`, `out_data`, `out_idx`).
  - The slot is free when `out_valid`=0, or when `out_valid`=1 and `out_ready`=1.
  - When the slot is free and at least one FIFO is non-empty, the arbiter pops one FIFO into the slot at the clock edge.
  - When the slot is free and both FIFOs are empty, `out_valid` goes to 0.
- Arbiter:
  - Round-robin, 1-bit pointer, reset value = low band.
  - If both FIFOs are non-empty, the band named by the pointer is granted. The pointer then moves to the other band.
  - If only one FIFO is non-empty, that band is granted. The pointer moves to the band not granted.
- Stall rule: while `out_valid`=1 and `out_ready`=0, all `out_*` hold stable.
- A sample written at edge t is never popped at the same edge t.

## Timing
- Reset values:
  - `out_valid`=0, `out_band`=0, `out_data`=0, `out_idx`=0, `ovf`=0.
  - FIFOs empty, phase bits 0, index counters 0, arbiter pointer = low.
- Reset is asynchronous on assertion. Deassertion is synchronised to `clk` internally with a 2-flop synchroniser.
- Reset asserted mid-operation clears all buffered data immediately. No partial word remains on the output.
- Latency (output slot free): a kept sample sampled at edge t appears with `out_valid`=1 after edge t+1.
- Throughput: one output word per cycle. Two bands decimated by 2 at one sample per cycle each give exactly one word per cycle. Any `out_ready` low cycle consumes FIFO margin.
- Simultaneous kept `y` and `z` at edge t: both are written. The low band is emitted after t+1, the high band after t+2 (pointer at reset value).
- FIFO count width: log2(DEPTH)+1 bits. Full = DEPTH, empty = 0. Read/write pointers wrap modulo DEPTH.

## Test plan
- Reset, then `y_valid`=`z_valid`=1 for 8 cycles with `y` = 1..8 and `z` = −1..−8, `out_ready`=1 → output sequence (band,data,idx): (0,1,0),(1,−1,0),(0,3,1),(1,−3,1),(0,5,2),(1,−5,2),(0,7,3),(1,−7,3); `ovf`=0.
- Only `y_valid` pulsed on alternate cycles with `y` = 10,11,12,13 → the kept samples are 10 and 12. Output is (0,10,0),(0,12,1), each 2 cycles after input; `out_band` stays 0.
- `out_ready`=0 while both bands stream continuously with DEPTH=16 → first word holds stable. Each FIFO fills after 32 valid cycles, not counting the word in the slot. The next kept sample sets `ovf`=2'b11. After releasing `out_ready`, `out_idx` shows a gap exactly at the dropped indices.
- Low FIFO full, `out_ready`=1, and a low-band pop coincides with a kept `y` → sample is stored, `ovf[0]` stays 0.
- Stream 1100 consecutive `y` samples with the consumer always ready → `out_idx` for the low band runs 0..511, wraps to 0, and continues to 37.
- Assert reset for 1 ns mid-stream with `out_valid`=1 → `out_valid`=0 and `ovf`=0 immediately. After release, the first kept sample is emitted with idx 0.
